// File: rtl/pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_e;

    // Shared down-counter width, sized for the largest of the three cycle parameters.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync2_bit.sv
// Two-flop synchronizer, async active-high reset to 0.
module sync2_bit (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses PLL_RST, waits for stable lock, releases RST_N_OUT.
// Optional retry limit (FAIL state) enabled by `define PLL_RESET_SEQ_RETRY_LIMIT_EN.
//   state     | meaning
//   PLL_RESET | PLL_RST high for RST_PULSE_CYCLES
//   WAIT_LOCK | waiting for synced lock, bounded by LOCK_TIMEOUT_CYCLES
//   STABLE    | lock must hold for LOCK_STABLE_CYCLES
//   RUN       | locked; RST_N_OUT released
//   FAIL      | retry limit exhausted, sticky until RST
module pll_reset_sequencer
    import pll_reset_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7,
    parameter int RETRY_W             = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               LOCKED_IN,
    output logic               PLL_RST,
    output logic               RST_N_OUT,
    output logic               LOCK_LOSS,
    output logic [RETRY_W-1:0] RETRY_COUNT,
    output logic               FAILED
);
    localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);

    if (RST_PULSE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 ||
        MAX_RETRIES < 0 || RETRY_W < 1) begin : g_bad_params
        $error("pll_reset_sequencer: illegal parameter value");
    end

    logic               lock_s;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_eff;
    logic               fresh_q;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               rst_n_q, rst_n_d;
    logic               lock_loss_q, lock_loss_d;
    logic               bump;

    sync2_bit u_lock_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (LOCKED_IN),
        .q_o   (lock_s)
    );

    // Counter resets to 0; the first cycle after reset behaves as a PLL_RESET entry.
    assign cnt_eff   = fresh_q ? PULSE_LOAD : cnt_q;
    assign retry_inc = (&retry_q) ? retry_q : retry_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_eff != '0) ? cnt_eff - 1'b1 : '0;
        retry_d     = retry_q;
        lock_loss_d = 1'b0;
        bump        = 1'b0;
        unique case (state_q)
            PLL_RESET: begin
                if (cnt_eff == '0) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TIMEOUT_LOAD;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = STABLE_LOAD;
                end else if (cnt_eff == '0) begin
                    bump = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TIMEOUT_LOAD;
                end else if (cnt_eff == '0) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    bump        = 1'b1;
                    lock_loss_d = 1'b1;
                end
            end
            default: begin
`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
                cnt_d = '0;
`else
                state_d = PLL_RESET;
                cnt_d   = PULSE_LOAD;
`endif
            end
        endcase
        if (bump) begin
            retry_d = retry_inc;
            state_d = PLL_RESET;
            cnt_d   = PULSE_LOAD;
`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
            if (retry_inc == RETRY_W'(MAX_RETRIES + 1)) begin
                state_d = FAIL;
                cnt_d   = '0;
            end
`endif
        end
        // Released one cycle after RUN entry, dropped on the same edge that leaves RUN.
        rst_n_d = (state_q == RUN) && (state_d == RUN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= PLL_RESET;
            cnt_q       <= '0;
            fresh_q     <= 1'b1;
            retry_q     <= '0;
            rst_n_q     <= 1'b0;
            lock_loss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fresh_q     <= 1'b0;
            retry_q     <= retry_d;
            rst_n_q     <= rst_n_d;
            lock_loss_q <= lock_loss_d;
        end
    end

    assign PLL_RST     = (state_q == PLL_RESET) || (state_q == FAIL);
    assign RST_N_OUT   = rst_n_q;
    assign LOCK_LOSS   = lock_loss_q;
    assign RETRY_COUNT = retry_q;
`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
    assign FAILED = (state_q == FAIL);
`else
    assign FAILED = 1'b0;
`endif
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer (pulse 4, timeout 20, stable 8, max retries 2).
module tb_pll_reset_sequencer;
    localparam int RW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          LOCKED_IN = 1'b0;
    logic          PLL_RST, RST_N_OUT, LOCK_LOSS, FAILED;
    logic [RW-1:0] RETRY_COUNT;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic          pll;
        logic          rn;
        logic          ll;
        logic          failed;
        logic [RW-1:0] rc;
    } out_t;

    typedef struct {
        string tag;
        logic  lock;
        int    n;
        out_t  exp;
    } seg_t;

    out_t sb_q[$];
    seg_t tbl[$];

    always #5 CLK = ~CLK;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2),
        .RETRY_W             (RW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .LOCKED_IN   (LOCKED_IN),
        .PLL_RST     (PLL_RST),
        .RST_N_OUT   (RST_N_OUT),
        .LOCK_LOSS   (LOCK_LOSS),
        .RETRY_COUNT (RETRY_COUNT),
        .FAILED      (FAILED)
    );

    function automatic out_t mk(input logic pll, input logic rn, input logic ll,
                                input logic f, input logic [RW-1:0] rc);
        out_t o;
        o = {pll, rn, ll, f, rc};
        return o;
    endfunction

    task automatic compare(input string tag, input int idx, input out_t exp);
        out_t act;
        act = {PLL_RST, RST_N_OUT, LOCK_LOSS, FAILED, RETRY_COUNT};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got pll_rst=%b rst_n=%b loss=%b failed=%b retry=%0d, want pll_rst=%b rst_n=%b loss=%b failed=%b retry=%0d",
                     tag, idx, act.pll, act.rn, act.ll, act.failed, act.rc,
                     exp.pll, exp.rn, exp.ll, exp.failed, exp.rc);
        end
    endtask

    // Drive lock for n cycles; outputs must equal exp after every edge.
    task automatic seg(input string tag, input logic lock, input int n, input out_t exp);
        for (int i = 0; i < n; i++) begin
            LOCKED_IN = lock;
            sb_q.push_back(exp);
            @(posedge CLK);
            #1;
            compare(tag, i, sb_q.pop_front());
        end
    endtask

    // Called 1 time unit after an edge; asserts RST between edges and checks outputs with no edge.
    task automatic reset_pulse(input string tag);
        #2 RST = 1'b1;
        #1 compare(tag, 0, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        compare(tag, 1, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        RST = 1'b0;
    endtask

    task automatic add(input string tag, input logic lock, input int n, input logic pll,
                       input logic rn, input logic ll, input logic f, input logic [RW-1:0] rc);
        seg_t s;
        s.tag  = tag;
        s.lock = lock;
        s.n    = n;
        s.exp  = mk(pll, rn, ll, f, rc);
        tbl.push_back(s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lock 10 cycles after PLL_RST falls, lock loss in RUN, then repeated timeouts.
        add("rst_pulse",   1'b0,  3, 1, 0, 0, 0, 0);
        add("wait_nolock", 1'b0, 10, 0, 0, 0, 0, 0);
        add("lock_settle", 1'b1, 11, 0, 0, 0, 0, 0);
        add("run",         1'b1,  5, 0, 1, 0, 0, 0);
        add("drop_sync",   1'b0,  2, 0, 1, 0, 0, 0);
        add("loss_edge",   1'b0,  1, 1, 0, 1, 0, 1);
        add("loss_pulse",  1'b0,  3, 1, 0, 0, 0, 1);
        add("timeout1",    1'b0, 20, 0, 0, 0, 0, 1);
        add("repulse2",    1'b0,  4, 1, 0, 0, 0, 2);
        add("timeout2",    1'b0, 20, 0, 0, 0, 0, 2);
`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
        add("fail_hold",   1'b0, 30, 1, 0, 0, 1, 3);
`else
        add("repulse3",    1'b0,  4, 1, 0, 0, 0, 3);
        add("timeout3",    1'b0, 20, 0, 0, 0, 0, 3);
        add("repulse4",    1'b0,  1, 1, 0, 0, 0, 4);
`endif

        reset_pulse("init_reset");
        foreach (tbl[k]) seg(tbl[k].tag, tbl[k].lock, tbl[k].n, tbl[k].exp);

        // Async reset must clear RETRY_COUNT (and FAILED) immediately.
        reset_pulse("rst_clears_retry");

        // Lock glitch: high 5, low 1, high; no retry, full stable window restarts.
        seg("g_pulse",  1'b0,  3, mk(1, 0, 0, 0, 0));
        seg("g_fall",   1'b0,  1, mk(0, 0, 0, 0, 0));
        seg("g_hi5",    1'b1,  5, mk(0, 0, 0, 0, 0));
        seg("g_lo1",    1'b0,  1, mk(0, 0, 0, 0, 0));
        seg("g_settle", 1'b1, 11, mk(0, 0, 0, 0, 0));
        seg("g_run",    1'b1,  3, mk(0, 1, 0, 0, 0));

        reset_pulse("rst_mid_run");

        seg("s_pulse",  1'b1,  3, mk(1, 0, 0, 0, 0));
        seg("s_wait",   1'b1,  1, mk(0, 0, 0, 0, 0));
        seg("s_stable", 1'b1,  4, mk(0, 0, 0, 0, 0));
        reset_pulse("rst_mid_stable");
        seg("r_pulse",  1'b1,  3, mk(1, 0, 0, 0, 0));
        seg("r_settle", 1'b1, 10, mk(0, 0, 0, 0, 0));
        seg("r_run",    1'b1,  2, mk(0, 1, 0, 0, 0));

        // Synced lock arrives on the last timeout cycle: lock wins, no retry.
        reset_pulse("rst_edge_case");
        seg("t_pulse",  1'b0,  3, mk(1, 0, 0, 0, 0));
        seg("t_wait",   1'b0, 18, mk(0, 0, 0, 0, 0));
        seg("t_lock",   1'b1, 11, mk(0, 0, 0, 0, 0));
        seg("t_run",    1'b1,  1, mk(0, 1, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
